// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with 2 write ports, 2 async read ports and a one-register-per-cycle clear sweep.
// Define REGFILE_BYPASS_EN to forward accepted writes to same-cycle reads.
`default_nettype none

module regfile_mp #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  if (DATA_W < 1 || NUM_REGS < 2 || (1 << ADDR_W) != NUM_REGS) begin : g_badParams
    $error("regfile_mp: NUM_REGS must be a power of two >= 2 equal to 2**ADDR_W, DATA_W >= 1");
  end

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_clrBusy;
  logic              r_clrDone;
  logic              r_wrReady;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_wrEn0;
  logic              w_wrEn1;
  logic              w_sweeping;
  logic              w_sweepLast;
  logic [ADDR_W-1:0] w_cntNext;

  assign w_wrEn0     = we0 & r_wrReady;
  assign w_wrEn1     = we1 & r_wrReady;
  assign w_sweeping  = (r_state == ST_SWEEP);
  assign w_cntNext   = r_cnt + ADDR_W'(1);
  assign w_sweepLast = (r_cnt == ADDR_W'(NUM_REGS - 1));

  // Status outputs are registered so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_clrBusy <= 1'b0;
      r_clrDone <= 1'b0;
      r_wrReady <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_clrDone <= 1'b0;
          if (clr_req) begin
            r_state   <= ST_SWEEP;
            r_cnt     <= '0;
            r_clrBusy <= 1'b1;
            r_wrReady <= 1'b0;
          end
        end
        ST_SWEEP: begin
          r_cnt <= w_cntNext;
          if (w_sweepLast) begin
            r_state   <= ST_IDLE;
            r_clrBusy <= 1'b0;
            r_clrDone <= 1'b0;
            r_wrReady <= 1'b1;
          end else begin
            r_clrDone <= (w_cntNext == ADDR_W'(NUM_REGS - 1));
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_clrBusy <= 1'b0;
          r_clrDone <= 1'b0;
          r_wrReady <= 1'b1;
        end
      endcase
    end
  end

  // Sweep zero has priority over writes; port 1 beats port 0 on an address clash.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset || (ZERO_R0 && i == 0)) begin
        r_regs[i] <= '0;
      end else if (w_sweeping && r_cnt == ADDR_W'(i)) begin
        r_regs[i] <= '0;
      end else if (w_wrEn1 && waddr1 == ADDR_W'(i)) begin
        r_regs[i] <= wdata1;
      end else if (w_wrEn0 && waddr0 == ADDR_W'(i)) begin
        r_regs[i] <= wdata0;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_fwd0;
  logic w_fwd1;

  assign w_fwd0 = w_wrEn0 & ~(ZERO_R0 && waddr0 == '0);
  assign w_fwd1 = w_wrEn1 & ~(ZERO_R0 && waddr1 == '0);

  // Port 1 is applied last so it wins when both ports hit the read address.
  always_comb begin
    rdata0 = r_regs[raddr0];
    if (w_fwd0 && waddr0 == raddr0) rdata0 = wdata0;
    if (w_fwd1 && waddr1 == raddr0) rdata0 = wdata1;
  end

  always_comb begin
    rdata1 = r_regs[raddr1];
    if (w_fwd0 && waddr0 == raddr1) rdata1 = wdata0;
    if (w_fwd1 && waddr1 == raddr1) rdata1 = wdata1;
  end
`else
  always_comb begin
    rdata0 = r_regs[raddr0];
  end

  always_comb begin
    rdata1 = r_regs[raddr1];
  end
`endif

  assign wr_ready = r_wrReady;
  assign clr_busy = r_clrBusy;
  assign clr_done = r_clrDone;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp; three instances cover the default,
// hard-wired R0 and 16x16 configurations. Expected values are hand-computed.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int A_RD0 = 0,  A_RD1 = 1,  A_RDY = 2,  A_BUSY = 3,  A_DONE = 4;
  localparam int Z_RD0 = 5,  Z_RD1 = 6,  Z_RDY = 7,  Z_BUSY = 8,  Z_DONE = 9;
  localparam int W_RD0 = 10, W_RD1 = 11, W_RDY = 12, W_BUSY = 13, W_DONE = 14;

  logic clk;
  logic resetA, resetZ, resetW;

  // Shared stimulus for the two 8x4 instances
  logic       we0, we1, clrReq;
  logic [1:0] waddr0, waddr1, raddr0, raddr1;
  logic [7:0] wdata0, wdata1;
  logic [7:0] rd0A, rd1A, rd0Z, rd1Z;
  logic       wrRdyA, busyA, doneA, wrRdyZ, busyZ, doneZ;

  // Stimulus for the 16x16 instance
  logic        we0W, we1W, clrReqW;
  logic [3:0]  waddr0W, waddr1W, raddr0W, raddr1W;
  logic [15:0] wdata0W, wdata1W, rd0W, rd1W;
  logic        wrRdyW, busyW, doneW;

  regfile_mp #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2), .ZERO_R0(1'b0)) dutA (
    .clk(clk), .reset(resetA),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .wr_ready(wrRdyA),
    .raddr0(raddr0), .rdata0(rd0A), .raddr1(raddr1), .rdata1(rd1A),
    .clr_req(clrReq), .clr_busy(busyA), .clr_done(doneA)
  );

  regfile_mp #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2), .ZERO_R0(1'b1)) dutZ (
    .clk(clk), .reset(resetZ),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .wr_ready(wrRdyZ),
    .raddr0(raddr0), .rdata0(rd0Z), .raddr1(raddr1), .rdata1(rd1Z),
    .clr_req(clrReq), .clr_busy(busyZ), .clr_done(doneZ)
  );

  regfile_mp #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .ZERO_R0(1'b0)) dutW (
    .clk(clk), .reset(resetW),
    .we0(we0W), .waddr0(waddr0W), .wdata0(wdata0W),
    .we1(we1W), .waddr1(waddr1W), .wdata1(wdata1W),
    .wr_ready(wrRdyW),
    .raddr0(raddr0W), .rdata0(rd0W), .raddr1(raddr1W), .rdata1(rd1W),
    .clr_req(clrReqW), .clr_busy(busyW), .clr_done(doneW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      A_RD0:  return {8'h00, rd0A};
      A_RD1:  return {8'h00, rd1A};
      A_RDY:  return {15'h0, wrRdyA};
      A_BUSY: return {15'h0, busyA};
      A_DONE: return {15'h0, doneA};
      Z_RD0:  return {8'h00, rd0Z};
      Z_RD1:  return {8'h00, rd1Z};
      Z_RDY:  return {15'h0, wrRdyZ};
      Z_BUSY: return {15'h0, busyZ};
      Z_DONE: return {15'h0, doneZ};
      W_RD0:  return rd0W;
      W_RD1:  return rd1W;
      W_RDY:  return {15'h0, wrRdyW};
      W_BUSY: return {15'h0, busyW};
      W_DONE: return {15'h0, doneW};
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [15:0] act;
    act = actual(e.sel);
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", e.name, act, e.exp, $time);
    end
  endtask

  // Monitor: drains every expectation queued for the current cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  task automatic pushExpect(input int sel, input logic [15:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iWe0, input logic [1:0] iA0, input logic [7:0] iD0,
                               input logic iWe1, input logic [1:0] iA1, input logic [7:0] iD1,
                               input logic [1:0] iR0, input logic [1:0] iR1, input logic iClr);
    step();
    we0 = iWe0; waddr0 = iA0; wdata0 = iD0;
    we1 = iWe1; waddr1 = iA1; wdata1 = iD1;
    raddr0 = iR0; raddr1 = iR1; clrReq = iClr;
  endtask

  task automatic applyW(input logic iWe0, input logic [3:0] iA0, input logic [15:0] iD0,
                        input logic iWe1, input logic [3:0] iA1, input logic [15:0] iD1,
                        input logic [3:0] iR0, input logic [3:0] iR1, input logic iClr);
    step();
    we0W = iWe0; waddr0W = iA0; wdata0W = iD0;
    we1W = iWe1; waddr1W = iA1; wdata1W = iD1;
    raddr0W = iR0; raddr1W = iR1; clrReqW = iClr;
  endtask

  task automatic expA(input logic [7:0] e0, input logic [7:0] e1);
    pushExpect(A_RD0, {8'h00, e0}, "a_rdata0");
    pushExpect(A_RD1, {8'h00, e1}, "a_rdata1");
  endtask

  task automatic expAStat(input logic rdy, input logic busy, input logic done);
    pushExpect(A_RDY,  {15'h0, rdy},  "a_wr_ready");
    pushExpect(A_BUSY, {15'h0, busy}, "a_clr_busy");
    pushExpect(A_DONE, {15'h0, done}, "a_clr_done");
  endtask

  initial begin
    resetA = 1'b1; resetZ = 1'b1; resetW = 1'b1;
    we0 = 1'b0; we1 = 1'b0; clrReq = 1'b0;
    waddr0 = '0; waddr1 = '0; raddr0 = '0; raddr1 = '0; wdata0 = '0; wdata1 = '0;
    we0W = 1'b0; we1W = 1'b0; clrReqW = 1'b0;
    waddr0W = '0; waddr1W = '0; raddr0W = '0; raddr1W = '0; wdata0W = '0; wdata1W = '0;
    step();
    resetA = 1'b0; resetZ = 1'b0; resetW = 1'b0;

    // Reset state
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
    expA(8'h00, 8'h00); expAStat(1, 0, 0);
    pushExpect(Z_RD0, 16'h0, "z_rdata0_reset");
    pushExpect(Z_RDY, 16'h1, "z_wr_ready_reset");
    pushExpect(W_RDY, 16'h1, "w_wr_ready_reset");
    pushExpect(W_BUSY, 16'h0, "w_clr_busy_reset");
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 2, 3, 0);
    expA(8'h00, 8'h00);

    // Single write, one-cycle visibility (or same-cycle with forwarding)
    applyStimulus(1, 2, 8'h5A, 0, 0, 8'h00, 2, 0, 0);
    pushExpect(A_RD0, BYP ? 16'h5A : 16'h00, "a_write_cycle_read");
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 2, 2, 0);
    expA(8'h5A, 8'h5A);

    // Same-address conflict: port 1 wins
    applyStimulus(1, 1, 8'h11, 1, 1, 8'h22, 1, 2, 0);
    pushExpect(A_RD0, BYP ? 16'h22 : 16'h00, "a_conflict_cycle_read");
    pushExpect(A_RD1, 16'h5A, "a_rdata1_r2");
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0);
    expA(8'h22, 8'h22);

    // Dual write to distinct addresses, R0 writable in A and dropped in Z
    applyStimulus(1, 0, 8'hA0, 1, 3, 8'h3C, 0, 3, 0);
    expA(BYP ? 8'hA0 : 8'h00, BYP ? 8'h3C : 8'h00);
    pushExpect(Z_RD0, 16'h0, "z_r0_no_forward");
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 3, 0);
    expA(8'hA0, 8'h3C);
    pushExpect(Z_RD0, 16'h0, "z_r0_zero");

    // Fill R0..R3 = 1..4, then request a sweep while also writing R2
    applyStimulus(1, 0, 8'h01, 1, 1, 8'h02, 2, 3, 0);
    expA(8'h5A, 8'h3C);
    applyStimulus(1, 2, 8'h03, 1, 3, 8'h04, 0, 1, 0);
    expA(8'h01, 8'h02);
    applyStimulus(1, 2, 8'h99, 0, 0, 8'h00, 3, 0, 1);
    expA(8'h04, 8'h01); expAStat(1, 0, 0);

    // Sweep: four cycles, R3=0x77 attempts dropped, partial contents readable
    applyStimulus(1, 3, 8'h77, 0, 0, 8'h00, 2, 3, 0);
    expA(8'h99, 8'h04); expAStat(0, 1, 0);
    applyStimulus(1, 3, 8'h77, 0, 0, 8'h00, 0, 1, 0);
    expA(8'h00, 8'h02); expAStat(0, 1, 0);
    applyStimulus(1, 3, 8'h77, 0, 0, 8'h00, 1, 2, 0);
    expA(8'h00, 8'h99); expAStat(0, 1, 0);
    applyStimulus(1, 3, 8'h77, 0, 0, 8'h00, 2, 3, 0);
    expA(8'h00, 8'h04); expAStat(0, 1, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 3, 1, 0);
    expA(8'h00, 8'h00); expAStat(1, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 2, 0);
    expA(8'h00, 8'h00);

    // clr_req held high re-triggers right after the return to IDLE
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    expAStat(1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
      expAStat(0, 1, (k == 4));
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    expAStat(1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
      expAStat(0, 1, (k == 4));
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    expAStat(1, 0, 0);

    // Hard-wired R0 instance: fresh reset, write R0, then reset mid-sweep
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    resetZ = 1'b1;
    applyStimulus(1, 0, 8'hFF, 1, 2, 8'h42, 0, 2, 0);
    resetZ = 1'b0;
    pushExpect(Z_RD0, 16'h0, "z_r0_write_cycle");
    pushExpect(Z_RD1, BYP ? 16'h42 : 16'h00, "z_r2_write_cycle");
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 2, 0);
    pushExpect(Z_RD0, 16'h0, "z_r0_after_write");
    pushExpect(Z_RD1, 16'h42, "z_r2_after_write");
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 2, 1);
    pushExpect(Z_BUSY, 16'h0, "z_busy_req_cycle");
    pushExpect(Z_RDY, 16'h1, "z_ready_req_cycle");
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 2, 2, 0);
    pushExpect(Z_BUSY, 16'h1, "z_busy_s1");
    pushExpect(Z_RD1, 16'h42, "z_r2_s1");
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 2, 2, 0);
    resetZ = 1'b1;
    pushExpect(Z_BUSY, 16'h1, "z_busy_s2");
    pushExpect(Z_DONE, 16'h0, "z_done_s2");
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 2, 2, 0);
    resetZ = 1'b0;
    pushExpect(Z_BUSY, 16'h0, "z_busy_after_reset");
    pushExpect(Z_DONE, 16'h0, "z_done_after_reset");
    pushExpect(Z_RDY, 16'h1, "z_ready_after_reset");
    pushExpect(Z_RD1, 16'h0, "z_r2_after_reset");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 2, 2, 0);
      pushExpect(Z_DONE, 16'h0, "z_no_done_pulse");
      pushExpect(Z_BUSY, 16'h0, "z_stays_idle");
    end

    // 16x16 instance: wide data, 16-cycle sweep
    applyW(1, 4'd15, 16'hBEEF, 1, 4'd7, 16'h1234, 4'd15, 4'd7, 0);
    pushExpect(W_RD0, BYP ? 16'hBEEF : 16'h0000, "w_r15_write_cycle");
    pushExpect(W_RD1, BYP ? 16'h1234 : 16'h0000, "w_r7_write_cycle");
    applyW(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd15, 4'd7, 0);
    pushExpect(W_RD0, 16'hBEEF, "w_r15");
    pushExpect(W_RD1, 16'h1234, "w_r7");
    applyW(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd15, 4'd7, 1);
    pushExpect(W_BUSY, 16'h0, "w_busy_req_cycle");
    for (int k = 0; k < 16; k++) begin
      applyW(1, 4'd15, 16'hFFFF, 0, 4'd0, 16'h0, 4'd15, 4'd7, 0);
      pushExpect(W_BUSY, 16'h1, "w_busy_sweep");
      pushExpect(W_RDY, 16'h0, "w_ready_sweep");
      pushExpect(W_DONE, (k == 15) ? 16'h1 : 16'h0, "w_done_sweep");
      pushExpect(W_RD0, 16'hBEEF, "w_r15_sweep");
      pushExpect(W_RD1, (k <= 7) ? 16'h1234 : 16'h0000, "w_r7_sweep");
    end
    applyW(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd15, 4'd7, 0);
    pushExpect(W_BUSY, 16'h0, "w_busy_end");
    pushExpect(W_DONE, 16'h0, "w_done_end");
    pushExpect(W_RDY, 16'h1, "w_ready_end");
    pushExpect(W_RD0, 16'h0, "w_r15_cleared");
    pushExpect(W_RD1, 16'h0, "w_r7_cleared");

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
